// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit words and writes them to consecutive
// instruction-memory addresses while holding the CPU in reset until the image is complete.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; cpu_rst holds its last value
//   RECV   | accepting stream bytes, packing them into the word register
//   WRITE  | one cycle: mem_we high with the packed word, counters advance
//   FINISH | one cycle: done pulse, CPU released from reset
module imem_loader #(
   parameter int ADDR_W     = 6,
   parameter int DEPTH      = 64,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [6:0]        i_len,
   input  logic              i_byte_valid,
   input  logic [7:0]        i_byte_data,
   output logic              o_byte_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_din,
   output logic              o_cpu_rst,
   output logic              o_busy,
   output logic              o_done,
   output logic [6:0]        o_words_loaded
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RECV   = 2'd1,
      S_WRITE  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   localparam logic [6:0] DEPTH_W = 7'(DEPTH);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [6:0]          r_len_eff;
   logic [6:0]          r_words;
   logic [1:0]          r_byte_cnt;
   logic [31:0]         r_word;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_din;
   logic                r_cpu_rst;
   logic                r_busy;
   logic                r_done;

   logic [6:0]          w_len_eff;
   logic                w_go;
   logic                w_accept;
   logic                w_word_full;
   logic [6:0]          w_words_inc;
   logic                w_last;
   logic [31:0]         w_packed;

   // A zero or oversized length means "fill the whole memory".
   assign w_len_eff   = ((i_len == 7'd0) || (i_len > DEPTH_W)) ? DEPTH_W : i_len;
   assign w_go        = (r_state == S_IDLE) && i_start && !i_abort;
   assign w_accept    = (r_state == S_RECV) && !i_abort && i_byte_valid;
   assign w_word_full = w_accept && (r_byte_cnt == 2'd3);
   assign w_words_inc = r_words + 7'd1;
   assign w_last      = (w_words_inc == r_len_eff);
   // Shift direction decides which end of the word the first byte lands in.
   assign w_packed    = BIG_ENDIAN ? {r_word[23:0], i_byte_data}
                                   : {i_byte_data, r_word[31:8]};

   // Ready is withheld while aborting so an abort never consumes a byte.
   assign o_byte_ready   = (r_state == S_RECV) && !i_abort;
   assign o_mem_we       = r_mem_we;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_din      = r_mem_din;
   assign o_cpu_rst      = r_cpu_rst;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_words_loaded = r_words;

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state decode; abort wins everywhere except FINISH.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_go) w_state_nxt = S_RECV;
         S_RECV: begin
            if (i_abort)          w_state_nxt = S_IDLE;
            else if (w_word_full) w_state_nxt = S_WRITE;
         end
         S_WRITE: begin
            if (i_abort)     w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_FINISH;
            else             w_state_nxt = S_RECV;
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath, counters and registered status outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_len_eff  <= '0;
         r_words    <= '0;
         r_byte_cnt <= '0;
         r_word     <= '0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_cpu_rst  <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_mem_we <= 1'b0;
         if (w_go) begin
            r_len_eff  <= w_len_eff;
            r_words    <= '0;
            r_byte_cnt <= '0;
            r_busy     <= 1'b1;
            r_cpu_rst  <= 1'b1;
         end
         if (w_accept) begin
            r_word     <= w_packed;
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end
         // Address and data are captured with the fourth byte and then held.
         if (w_word_full) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_words[ADDR_W-1:0];
            r_mem_din  <= w_packed;
         end
         if ((r_state == S_RECV) && i_abort) r_busy <= 1'b0;
         if (r_state == S_WRITE) begin
            if (i_abort) begin
               r_busy <= 1'b0;
            end else begin
               r_words    <= w_words_inc;
               r_byte_cnt <= '0;
               if (w_last) begin
                  r_done    <= 1'b1;
                  r_cpu_rst <= 1'b0;
                  r_busy    <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a big-endian and a little-endian instance share all stimulus.
module tb_imem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, abort, bv;
   logic [6:0] len;
   logic [7:0] bd;

   logic       rdy_b, we_b, cpu_b, busy_b, done_b;
   logic [5:0] addr_b;
   logic [31:0] din_b;
   logic [6:0] wl_b;
   logic       rdy_l, we_l, cpu_l, busy_l, done_l;
   logic [5:0] addr_l;
   logic [31:0] din_l;
   logic [6:0] wl_l;

   imem_loader #(.ADDR_W(6), .DEPTH(64), .BIG_ENDIAN(1'b1)) u_be (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_len(len),
      .i_byte_valid(bv), .i_byte_data(bd), .o_byte_ready(rdy_b), .o_mem_we(we_b),
      .o_mem_addr(addr_b), .o_mem_din(din_b), .o_cpu_rst(cpu_b), .o_busy(busy_b),
      .o_done(done_b), .o_words_loaded(wl_b));

   imem_loader #(.ADDR_W(6), .DEPTH(64), .BIG_ENDIAN(1'b0)) u_le (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_len(len),
      .i_byte_valid(bv), .i_byte_data(bd), .o_byte_ready(rdy_l), .o_mem_we(we_l),
      .o_mem_addr(addr_l), .o_mem_din(din_l), .o_cpu_rst(cpu_l), .o_busy(busy_l),
      .o_done(done_l), .o_words_loaded(wl_l));

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic done_cpu = 1'b1;

   logic [5:0]  wa_b[$], wa_l[$];
   logic [31:0] wd_b[$], wd_l[$];
   int          wcyc[$];
   logic [7:0]  tx[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Write/done monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (we_b) begin
         wa_b.push_back(addr_b);
         wd_b.push_back(din_b);
         wcyc.push_back(cyc);
      end
      if (we_l) begin
         wa_l.push_back(addr_l);
         wd_l.push_back(din_l);
      end
      if (done_b) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
         done_cpu <= cpu_b;
      end
   end

   // Reference: word k is bytes 4k..4k+3 of the image, ordered per endianness.
   function automatic logic [31:0] exp_word(int k, bit be);
      if (be) return {tx[4*k], tx[4*k+1], tx[4*k+2], tx[4*k+3]};
      return {tx[4*k+3], tx[4*k+2], tx[4*k+1], tx[4*k]};
   endfunction

   task automatic clear_mon();
      wa_b.delete(); wd_b.delete(); wa_l.delete(); wd_l.delete(); wcyc.delete();
   endtask

   task automatic do_start(input logic [6:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed(input int from, input int to, input int gap_pct);
      int idx = from;
      int guard = 0;
      while (idx < to && guard < 4000) begin
         bv = ($urandom_range(99) >= gap_pct);
         bd = tx[idx];
         #1;
         if (bv && rdy_b) idx++;
         @(negedge clk);
         guard++;
      end
      bv = 1'b0;
      if (idx < to) begin
         n_cmp++; n_err++;
         $display("FAIL feed_timeout: sent %0d bytes, required %0d", idx, to);
      end
   endtask

   task automatic wait_done(input int base);
      int g = 0;
      while (done_cnt == base && g < 60) begin
         @(negedge clk);
         #1;
         g++;
      end
      n_cmp++;
      if (done_cnt == base) begin
         n_err++;
         $display("FAIL done_timeout: done count %0d, required %0d", done_cnt, base + 1);
      end
   endtask

   task automatic test_reset();
      logic [48:0] exp_v;
      exp_v = {1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 7'd0, 1'b1};
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; bv = 1'b0; bd = 8'h00; len = 7'd0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({rdy_b, we_b, addr_b, din_b, busy_b, done_b, wl_b, cpu_b} !== exp_v) begin
         n_err++;
         $display("FAIL reset_be: got %h, required %h",
                  {rdy_b, we_b, addr_b, din_b, busy_b, done_b, wl_b, cpu_b}, exp_v);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({rdy_l, we_l, addr_l, din_l, busy_l, done_l, wl_l, cpu_l} !== exp_v) begin
         n_err++;
         $display("FAIL idle_le: got %h, required %h",
                  {rdy_l, we_l, addr_l, din_l, busy_l, done_l, wl_l, cpu_l}, exp_v);
      end
   endtask

   task automatic test_basic();
      int base;
      @(negedge clk);
      tx = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      clear_mon();
      base = done_cnt;
      do_start(7'd2);
      n_cmp++;
      if ({busy_b, cpu_b, rdy_b} !== 3'b111) begin
         n_err++;
         $display("FAIL basic_start: busy/cpu_rst/ready %b, required 111", {busy_b, cpu_b, rdy_b});
      end
      feed(0, 8, 0);
      wait_done(base);
      n_cmp++;
      if (wd_b.size() != 2 || wd_l.size() != 2) begin
         n_err++;
         $display("FAIL basic_nwrites: be %0d le %0d, required 2", wd_b.size(), wd_l.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (wa_b[k] !== 6'(k) || wd_b[k] !== exp_word(k, 1'b1) ||
                wa_l[k] !== 6'(k) || wd_l[k] !== exp_word(k, 1'b0)) begin
               n_err++;
               $display("FAIL basic_word%0d: be %h@%0d le %h@%0d, required %h / %h", k,
                        wd_b[k], wa_b[k], wd_l[k], wa_l[k], exp_word(k, 1'b1), exp_word(k, 1'b0));
            end
         end
         n_cmp++;
         if (done_cyc != wcyc[1] + 1) begin
            n_err++;
            $display("FAIL basic_done_timing: done cycle %0d, required %0d", done_cyc, wcyc[1] + 1);
         end
      end
      n_cmp++;
      if ({done_cpu, cpu_b, busy_b, wl_b} !== {1'b0, 1'b0, 1'b0, 7'd2}) begin
         n_err++;
         $display("FAIL basic_status: cpu@done %b cpu %b busy %b words %0d, required 0 0 0 2",
                  done_cpu, cpu_b, busy_b, wl_b);
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({cpu_b, wl_b, we_b} !== {1'b0, 7'd2, 1'b0}) begin
         n_err++;
         $display("FAIL basic_idle_hold: cpu %b words %0d we %b, required 0 2 0", cpu_b, wl_b, we_b);
      end
   endtask

   task automatic test_little_endian();
      int base;
      @(negedge clk);
      tx = {8'h12, 8'h34, 8'h56, 8'h78};
      clear_mon();
      base = done_cnt;
      do_start(7'd1);
      n_cmp++;
      if ({busy_l, cpu_l} !== 2'b11) begin
         n_err++;
         $display("FAIL le_start_cpu_rst: busy/cpu_rst %b, required 11", {busy_l, cpu_l});
      end
      feed(0, 4, 0);
      wait_done(base);
      n_cmp++;
      if (wd_l.size() != 1 || wd_l[0] !== 32'h78563412 || wa_l[0] !== 6'd0 || wd_b[0] !== 32'h12345678) begin
         n_err++;
         $display("FAIL le_word: le %h be %h count %0d, required 78563412 12345678 1",
                  (wd_l.size() > 0) ? wd_l[0] : 32'hx, (wd_b.size() > 0) ? wd_b[0] : 32'hx, wd_l.size());
      end
   endtask

   task automatic test_len_max();
      logic [6:0] lens [2];
      int base;
      int bad;
      lens[0] = 7'd0;
      lens[1] = 7'd100;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         tx.delete();
         for (int i = 0; i < 256; i++) tx.push_back(8'(i));
         clear_mon();
         base = done_cnt;
         do_start(lens[r]);
         feed(0, 256, 30);
         wait_done(base);
         n_cmp++;
         if (wd_b.size() != 64 || wd_l.size() != 64) begin
            n_err++;
            $display("FAIL lenmax%0d_nwrites: %0d, required 64", lens[r], wd_b.size());
         end else begin
            bad = 0;
            for (int k = 0; k < 64; k++)
               if (wa_b[k] !== 6'(k) || wd_b[k] !== exp_word(k, 1'b1) || wd_l[k] !== exp_word(k, 1'b0))
                  bad++;
            n_cmp++;
            if (bad != 0) begin
               n_err++;
               $display("FAIL lenmax%0d_image: %0d bad words, required 0", lens[r], bad);
            end
         end
         n_cmp++;
         if (wl_b !== 7'd64 || cpu_b !== 1'b0) begin
            n_err++;
            $display("FAIL lenmax%0d_status: words %0d cpu %b, required 64 0", lens[r], wl_b, cpu_b);
         end
      end
   endtask

   task automatic test_abort();
      int base;
      @(negedge clk);
      tx.delete();
      for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
      clear_mon();
      base = done_cnt;
      do_start(7'd4);
      feed(0, 6, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      n_cmp++;
      if (wd_b.size() != 1 || wa_b[0] !== 6'd0 || wd_b[0] !== exp_word(0, 1'b1)) begin
         n_err++;
         $display("FAIL abort_writes: count %0d, required 1 write of %h at 0", wd_b.size(), exp_word(0, 1'b1));
      end
      n_cmp++;
      if ({busy_b, done_b, cpu_b, rdy_b} !== 4'b0010 || done_cnt != base) begin
         n_err++;
         $display("FAIL abort_status: busy/done/cpu/ready %b dones %0d, required 0010 %0d",
                  {busy_b, done_b, cpu_b, rdy_b}, done_cnt, base);
      end
      // abort together with start in IDLE
      start = 1'b1; abort = 1'b1; len = 7'd1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1;
      n_cmp++;
      if ({busy_b, rdy_b, cpu_b} !== 3'b001) begin
         n_err++;
         $display("FAIL abort_start_idle: busy/ready/cpu %b, required 001", {busy_b, rdy_b, cpu_b});
      end
      // abort during FINISH is ignored
      @(negedge clk);
      tx = {8'hA5, 8'h5A, 8'h3C, 8'hC3};
      clear_mon();
      base = done_cnt;
      do_start(7'd1);
      feed(0, 4, 0);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      wait_done(base);
      n_cmp++;
      if (cpu_b !== 1'b0 || wl_b !== 7'd1 || wd_b.size() != 1) begin
         n_err++;
         $display("FAIL abort_finish: cpu %b words %0d writes %0d, required 0 1 1", cpu_b, wl_b, wd_b.size());
      end
   endtask

   task automatic test_reset_mid_and_start_busy();
      int base;
      int nw;
      @(negedge clk);
      tx.delete();
      for (int i = 0; i < 12; i++) tx.push_back(8'($urandom));
      clear_mon();
      base = done_cnt;
      do_start(7'd3);
      feed(0, 6, 0);
      bv = 1'b1; bd = tx[6];
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({rdy_b, we_b, addr_b, din_b, busy_b, done_b, wl_b, cpu_b} !==
          {1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 7'd0, 1'b1}) begin
         n_err++;
         $display("FAIL midload_reset: got %h, required reset values",
                  {rdy_b, we_b, addr_b, din_b, busy_b, done_b, wl_b, cpu_b});
      end
      nw = wd_b.size();
      bv = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      n_cmp++;
      if (wd_b.size() != nw || nw != 1 || done_cnt != base) begin
         n_err++;
         $display("FAIL midload_no_write: writes %0d dones %0d, required 1 %0d", wd_b.size(), done_cnt, base);
      end
      @(negedge clk);
      tx.delete();
      for (int i = 0; i < 12; i++) tx.push_back(8'($urandom));
      clear_mon();
      base = done_cnt;
      do_start(7'd3);
      feed(0, 5, $urandom_range(40));
      start = 1'b1; len = 7'd1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy_b !== 1'b1) begin
         n_err++;
         $display("FAIL start_busy_status: busy %b, required 1", busy_b);
      end
      feed(5, 12, 20);
      wait_done(base);
      n_cmp++;
      if (wd_b.size() != 3 || wl_b !== 7'd3) begin
         n_err++;
         $display("FAIL start_busy_len: writes %0d words %0d, required 3 3", wd_b.size(), wl_b);
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (wa_b[k] !== 6'(k) || wd_b[k] !== exp_word(k, 1'b1)) begin
               n_err++;
               $display("FAIL start_busy_word%0d: %h@%0d, required %h@%0d", k, wd_b[k], wa_b[k], exp_word(k, 1'b1), k);
            end
         end
      end
   endtask

   task automatic test_random();
      int base;
      int l;
      int bad;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         l = $urandom_range(1, 8);
         tx.delete();
         for (int i = 0; i < 4 * l; i++) tx.push_back(8'($urandom));
         clear_mon();
         base = done_cnt;
         do_start(7'(l));
         feed(0, 4 * l, $urandom_range(50));
         wait_done(base);
         bad = 0;
         if (wd_b.size() != l || wd_l.size() != l) bad = 100;
         else
            for (int k = 0; k < l; k++)
               if (wa_b[k] !== 6'(k) || wd_b[k] !== exp_word(k, 1'b1) ||
                   wa_l[k] !== 6'(k) || wd_l[k] !== exp_word(k, 1'b0))
                  bad++;
         n_cmp++;
         if (bad != 0 || wl_b !== 7'(l) || done_cpu !== 1'b0) begin
            n_err++;
            $display("FAIL random%0d: len %0d writes %0d bad %0d words %0d cpu@done %b", r, l,
                     wd_b.size(), bad, wl_b, done_cpu);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_little_endian();
      test_len_max();
      test_abort();
      test_reset_mid_and_start_busy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
